// File: rtl/sram_mem_stage_wbuf_pkg.sv
// sram_mem_stage_wbuf_pkg: shared FSM state encoding for the MEM-stage SRAM controller
package sram_mem_stage_wbuf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DRAIN, S_READ, S_RDONE} state_t;
endpackage

// File: rtl/sram_mem_stage_wbuf_if.sv
// sram_mem_stage_wbuf_if: pipeline-side MEM-stage bus between the pipeline and the SRAM controller
interface sram_mem_stage_wbuf_if #(parameter int DATA_W = 32, parameter int CNT_W = 3);
  logic mem_r_en, mem_w_en, wb_en;
  logic [31:0] alu_result;
  logic [DATA_W-1:0] st_value, memory_result;
  logic mem_wb_en_out, sram_freeze;
  logic [CNT_W-1:0] wbuf_count;
  modport slave(input mem_r_en, mem_w_en, wb_en, alu_result, st_value,
                output memory_result, mem_wb_en_out, sram_freeze, wbuf_count);
  modport master(output mem_r_en, mem_w_en, wb_en, alu_result, st_value,
                 input memory_result, mem_wb_en_out, sram_freeze, wbuf_count);
endinterface

// File: rtl/sram_mem_stage_wbuf_fifo.sv
// sram_mem_stage_wbuf_fifo: posted-write FIFO; a push while full and popping reads the old head first
module sram_mem_stage_wbuf_fifo #(parameter int W = 50, parameter int DEPTH = 4) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  always_ff @(posedge clock) begin
    if (reset) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/sram_mem_stage_wbuf.sv
// sram_mem_stage_wbuf: MEM-stage SRAM controller with posted write buffer and multi-beat wait-stated access
module sram_mem_stage_wbuf
  import sram_mem_stage_wbuf_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  sram_mem_stage_wbuf_if.slave   pipe,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);
  localparam int BEATS    = DATA_W / SRAM_DQ_W;
  localparam int BEAT_W   = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WORD_LSB = $clog2(DATA_W / 8);
  localparam int WAIT_W   = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam int CNT_W    = $clog2(WBUF_DEPTH) + 1;
  localparam int FW       = SRAM_ADDR_W + DATA_W;
  state_t state;
  logic [BEAT_W-1:0] beat;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEATS-1:0][SRAM_DQ_W-1:0] wr_data, asm_word, rd_word;
  logic [FW-1:0] head;
  logic [CNT_W-1:0] count;
  logic [SRAM_ADDR_W-1:0] word_idx, base;
  logic full, empty, load, store, push, pop, rd_active, wr_active, beat_end, acc_end;
  assign load = pipe.mem_r_en;
  assign store = pipe.mem_w_en && !load;
  assign word_idx = SRAM_ADDR_W'(pipe.alu_result >> WORD_LSB);
  assign wr_active = state == S_WRITE || state == S_DRAIN;
  // an empty-buffer load starts its first read beat straight out of IDLE
  assign rd_active = state == S_READ || (state == S_IDLE && load && empty);
  assign beat_end = wait_cnt == WAIT_W'(WAIT_CYCLES - 1);
  assign acc_end = beat_end && beat == BEAT_W'(BEATS - 1);
  assign pop = wr_active && acc_end;
  assign push = store && (!full || pop);
  assign wr_data = head[DATA_W-1:0];
  assign base = wr_active ? head[FW-1 -: SRAM_ADDR_W] : word_idx;
  assign SRAM_ADDR = base * SRAM_ADDR_W'(BEATS) + SRAM_ADDR_W'(beat);
  assign SRAM_DQ = wr_active ? wr_data[beat] : {SRAM_DQ_W{1'bz}};
  assign SRAM_CE_N = !(wr_active || rd_active);
  assign SRAM_UB_N = SRAM_CE_N;
  assign SRAM_LB_N = SRAM_CE_N;
  assign SRAM_WE_N = !wr_active;
  assign SRAM_OE_N = !rd_active;
  assign pipe.sram_freeze = (load && state != S_RDONE) || (store && !push);
  assign pipe.mem_wb_en_out = pipe.wb_en && !pipe.sram_freeze;
  assign pipe.wbuf_count = count;
  always_comb begin
    rd_word = asm_word;
    rd_word[beat] = SRAM_DQ;
  end
  sram_mem_stage_wbuf_fifo #(.W(FW), .DEPTH(WBUF_DEPTH)) u_fifo (
    .clock, .reset, .push, .pop,
    .din({word_idx, pipe.st_value}),
    .dout(head), .full, .empty, .count
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      beat <= '0;
      wait_cnt <= '0;
      asm_word <= '0;
      pipe.memory_result <= '0;
    end else begin
      wait_cnt <= (rd_active || wr_active) && !beat_end ? wait_cnt + WAIT_W'(1) : '0;
      beat <= !(rd_active || wr_active) || acc_end ? '0 : beat_end ? beat + BEAT_W'(1) : beat;
      if (rd_active && beat_end) asm_word <= rd_word;
      if (rd_active && acc_end) pipe.memory_result <= rd_word;
      case (state)
        S_IDLE:          state <= load ? (empty ? (acc_end ? S_RDONE : S_READ) : S_DRAIN)
                                      : (empty ? S_IDLE : S_WRITE);
        S_WRITE, S_DRAIN: if (pop) state <= (count != CNT_W'(1) || push) ? (load ? S_DRAIN : S_WRITE)
                                                                          : (load ? S_READ : S_IDLE);
        S_READ:          if (acc_end) state <= S_RDONE;
        default:         state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_mem_stage_wbuf.sv
// tb_sram_mem_stage_wbuf: directed table-driven bench with a behavioural 16-bit SRAM model
module tb_sram_mem_stage_wbuf;
  logic clk = 0;
  logic rst = 1;
  logic init_mem = 1;
  wire [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic ub_n, lb_n, we_n, ce_n, oe_n;
  logic [15:0] sram [64];
  logic [17:0] wa_q [$];
  logic [15:0] wd_q [$];
  int n_chk = 0;
  int n_fail = 0;
  sram_mem_stage_wbuf_if #(.DATA_W(32), .CNT_W(3)) pipe ();
  sram_mem_stage_wbuf dut (
    .clock(clk), .reset(rst), .pipe(pipe.slave), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );
  always #5 clk = ~clk;
  assign sram_dq = (!oe_n && !ce_n) ? sram[sram_addr[5:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) sram[i] <= '0;
      sram[2] <= 16'h1234;
      sram[3] <= 16'hABCD;
    end else if (!we_n && !ce_n) begin
      sram[sram_addr[5:0]] <= sram_dq;
      wa_q.push_back(sram_addr);
      wd_q.push_back(sram_dq);
    end
  end
  typedef struct {
    logic rd, wr;
    logic [31:0] addr, data, res;
    int idle, cnt, frz;
  } vec_t;
  vec_t vt [11];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] exp_res, input int idle, input int exp_cnt, input int exp_frz,
                    input string nm);
    int frz;
    pipe.mem_r_en = rd;
    pipe.mem_w_en = wr;
    pipe.alu_result = a;
    pipe.st_value = d;
    pipe.wb_en = 1;
    #1;
    check({nm, " count"}, 32'(pipe.wbuf_count), exp_cnt);
    check({nm, " wb_out"}, 32'(pipe.mem_wb_en_out), 32'(exp_frz == 0));
    frz = 0;
    while (pipe.sram_freeze && frz < 40) begin
      frz++;
      @(negedge clk);
      #1;
    end
    check({nm, " freeze"}, frz, exp_frz);
    if (rd) check({nm, " result"}, pipe.memory_result, exp_res);
    @(negedge clk);
    pipe.mem_r_en = 0;
    pipe.mem_w_en = 0;
    pipe.wb_en = 0;
    repeat (idle) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    int b;
    vt[0]  = '{1, 0, 32'h04, 32'h0,        32'hABCD1234, 0, 0, 4};
    vt[1]  = '{1, 1, 32'h04, 32'h55555555, 32'hABCD1234, 0, 0, 4};
    vt[2]  = '{0, 1, 32'h20, 32'h11223344, 32'h0,        0, 0, 0};
    vt[3]  = '{1, 0, 32'h20, 32'h0,        32'h11223344, 0, 1, 9};
    vt[4]  = '{0, 1, 32'h24, 32'h99887766, 32'h0,        1, 0, 0};
    vt[5]  = '{1, 0, 32'h24, 32'h0,        32'h99887766, 0, 1, 8};
    vt[6]  = '{0, 1, 32'h28, 32'h0BADF00D, 32'h0,        0, 0, 0};
    vt[7]  = '{0, 1, 32'h2C, 32'hCAFEBABE, 32'h0,        0, 1, 0};
    vt[8]  = '{1, 0, 32'h28, 32'h0,        32'h0BADF00D, 0, 2, 12};
    vt[9]  = '{1, 0, 32'h2C, 32'h0,        32'hCAFEBABE, 0, 0, 4};
    vt[10] = '{1, 0, 32'h04, 32'h0,        32'hABCD1234, 0, 0, 4};
    pipe.mem_r_en = 0;
    pipe.mem_w_en = 0;
    pipe.wb_en = 0;
    pipe.alu_result = 0;
    pipe.st_value = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    init_mem = 0;
    #1;
    check("reset freeze", 32'(pipe.sram_freeze), 0);
    check("reset count", 32'(pipe.wbuf_count), 0);
    check("reset result", pipe.memory_result, 0);
    check("reset strobes", 32'({ce_n, we_n, oe_n, ub_n, lb_n}), 32'h1F);
    @(negedge clk);
    // single posted store: two beats, each WE_N low for two cycles
    wa_q.delete();
    wd_q.delete();
    op(0, 1, 32'h8, 32'hDEADBEEF, 0, 6, 0, 0, "store8");
    check("store8 beats", wa_q.size(), 4);
    for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
      check($sformatf("store8 addr%0d", k), 32'(wa_q[k]), 4 + k / 2);
      check($sformatf("store8 data%0d", k), 32'(wd_q[k]), k < 2 ? 32'hBEEF : 32'hDEAD);
    end
    check("store8 ce idle", 32'(ce_n), 1);
    for (int i = 0; i < 11; i++)
      op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, vt[i].res, vt[i].idle, vt[i].cnt, vt[i].frz,
         $sformatf("vec%0d", i));
    // five back-to-back stores: the fifth waits for the first pop
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < 5; i++) begin
      d = {16'hA000 + i[15:0], 16'hB000 + i[15:0]};
      op(0, 1, i * 4, d, 0, i == 4 ? 20 : 0, i, i == 4 ? 1 : 0, $sformatf("burst%0d", i));
    end
    check("burst beats", wa_q.size(), 20);
    for (int k = 0; k < 20 && k < wa_q.size(); k++) begin
      b = k / 2;
      check($sformatf("burst addr%0d", k), 32'(wa_q[k]), b);
      check($sformatf("burst data%0d", k), 32'(wd_q[k]), (b % 2) ? 32'hA000 + b / 2 : 32'hB000 + b / 2);
    end
    check("burst count", 32'(pipe.wbuf_count), 0);
    // reset during the second read beat of an empty-buffer load
    pipe.mem_r_en = 1;
    pipe.alu_result = 32'h8;
    pipe.wb_en = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst oe active", 32'(oe_n), 0);
    rst = 1;
    pipe.mem_r_en = 0;
    @(negedge clk);
    rst = 0;
    #1;
    check("rst freeze", 32'(pipe.sram_freeze), 0);
    check("rst strobes", 32'({ce_n, we_n, oe_n}), 32'h7);
    check("rst count", 32'(pipe.wbuf_count), 0);
    check("rst result", pipe.memory_result, 0);
    @(negedge clk);
    // reset with buffered stores discards them
    op(0, 1, 32'h30, 32'h01020304, 0, 0, 0, 0, "disc0");
    op(0, 1, 32'h34, 32'h05060708, 0, 0, 1, 0, "disc1");
    rst = 1;
    @(negedge clk);
    rst = 0;
    wa_q.delete();
    #1;
    check("disc count", 32'(pipe.wbuf_count), 0);
    repeat (12) @(negedge clk);
    check("disc writes", wa_q.size(), 0);
    check("disc ce", 32'(ce_n), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
